// File: rtl/modmul7681_rr_sched.sv
// Round-robin scheduler sharing one signed 13x13 multiplier and a 3-stage
// mod-7681 reduction pipeline among NREQ requesters. Issue is credit-gated
// against the result FIFO so the non-stallable pipeline never overflows it.
module modmul7681_rr_sched #(
  parameter int NREQ       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [13*NREQ-1:0]     req_a,
  input  logic [13*NREQ-1:0]     req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [IDW-1:0]         res_id,
  output logic signed [12:0]     res_c,
  output logic                   idle
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CREDITS = CW'(FIFO_DEPTH);
  // floor(2^37 / 7681); quotient estimate is exact or one low, fixed in stage 3
  localparam logic signed [26:0] BARRETT_M = 27'sd17893367;
  localparam int BARRETT_K = 37;

  logic [CW-1:0]  credits;
  logic [IDW-1:0] rrPtr;
  logic           grantValid;
  logic [IDW-1:0] grantId;
  logic           popFire;

  // Round-robin search starting at rrPtr; lowest offset wins, only with credit left
  always_comb begin
    grantValid = 1'b0;
    grantId    = '0;
    if (credits != '0) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (req_valid[(int'(rrPtr) + k) % NREQ]) begin
          grantValid = 1'b1;
          grantId    = IDW'((int'(rrPtr) + k) % NREQ);
        end
      end
    end
  end

  assign req_ready = grantValid ? (NREQ'(1) << grantId) : '0;

  // Operand mux for the granted lane
  logic signed [12:0] selA, selB;
  assign selA = $signed(req_a[13*grantId +: 13]);
  assign selB = $signed(req_b[13*grantId +: 13]);

  // Datapath registers (no reset: contents only matter under a set valid bit)
  logic signed [24:0] mZ;
  logic signed [25:0] t1;
  logic signed [52:0] prod1;
  logic signed [15:0] r2;
  logic signed [12:0] outC;
  logic [IDW-1:0]     id0, id1, id2, id3;

  logic signed [25:0] tComb;
  logic signed [25:0] qComb;
  logic signed [15:0] rFix;

  // Offset by Q/2 so the floor quotient becomes a rounded one (centred residue)
  assign tComb = mZ + 26'sd3840;
  assign qComb = 26'(prod1 >>> BARRETT_K);

  // Final correction: remainder lies in [0, 2Q); fold once, then recentre
  always_comb begin
    rFix = r2;
    if (r2 >= 16'sd7681) begin
      rFix = r2 - 16'sd7681;
    end
  end

  // Multiply and three reduction stages, with the requester tag riding along
  always_ff @(posedge clk) begin
    mZ    <= selA * selB;
    id0   <= grantId;
    t1    <= tComb;
    prod1 <= tComb * BARRETT_M;
    id1   <= id0;
    r2    <= 16'(t1 - qComb * 26'sd7681);
    id2   <= id1;
    outC  <= 13'(rFix - 16'sd3840);
    id3   <= id2;
  end

  logic v0, v1, v2, v3;

  // Valid-bit shift register tracking ops through the pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v0 <= grantValid;
      v1 <= v0;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Result FIFO: show-ahead, extra pointer bit distinguishes full from empty
  logic [IDW+12:0] fifoMem [FIFO_DEPTH];
  logic [PW:0]     wrPtr, rdPtr;
  logic [IDW+12:0] headWord;

  assign res_valid = (wrPtr != rdPtr);
  assign popFire   = res_valid & res_ready;
  assign headWord  = fifoMem[rdPtr[PW-1:0]];
  assign res_id    = res_valid ? headWord[IDW+12:13] : '0;
  assign res_c     = res_valid ? $signed(headWord[12:0]) : 13'sd0;

  // FIFO storage write; credits guarantee there is room whenever v3 is set
  always_ff @(posedge clk) begin
    if (v3) begin
      fifoMem[wrPtr[PW-1:0]] <= {id3, outC};
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (v3)      wrPtr <= wrPtr + 1'b1;
      if (popFire) rdPtr <= rdPtr + 1'b1;
    end
  end

  // Credit counter and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= FULL_CREDITS;
      rrPtr   <= '0;
    end else begin
      if (grantValid && !popFire) begin
        credits <= credits - CW'(1);
      end else if (popFire && !grantValid) begin
        credits <= credits + CW'(1);
      end
      if (grantValid) begin
        rrPtr <= (int'(grantId) == NREQ - 1) ? '0 : grantId + IDW'(1);
      end
    end
  end

  assign idle = (credits == FULL_CREDITS);

endmodule

// File: tb/tb_modmul7681_rr_sched.sv
// Testbench for modmul7681_rr_sched: directed scenarios plus random traffic,
// checked against a queue-based reference of grants, latency and mod-7681 results.
module tb_modmul7681_rr_sched;

  localparam int NREQ = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int IDW = 2;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [13*NREQ-1:0]   req_a;
  logic [13*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [IDW-1:0]       res_id;
  logic signed [12:0]   res_c;
  logic                 idle;

  modmul7681_rr_sched #(.NREQ(NREQ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_c(res_c), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int id; int c; int acc; } op_t;

  op_t inflight[$];
  op_t fifoQ[$];
  int  laneA[NREQ];
  int  laneB[NREQ];
  int  rr = 0;
  int  edgeNum = 0;
  int  obsAccepts = 0;
  int  checks = 0;
  int  failures = 0;

  function automatic int ref_mod(input int a, input int b);
    int c;
    c = (a * b) % 7681;
    if (c > 3840) c -= 7681;
    else if (c < -3840) c += 7681;
    return c;
  endfunction

  function automatic int rnd_op();
    return int'($urandom_range(7680)) - 3840;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // One clock cycle: check outputs against the model, then advance the model
  task automatic step();
    int  g;
    bit  pop;
    op_t e;
    for (int i = 0; i < NREQ; i++) begin
      req_a[13*i +: 13] = 13'(laneA[i]);
      req_b[13*i +: 13] = 13'(laneB[i]);
    end
    #1;
    g = -1;
    if (inflight.size() + fifoQ.size() < FIFO_DEPTH) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(rr + k) % NREQ]) g = (rr + k) % NREQ;
      end
    end
    chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    if (req_ready != '0) obsAccepts++;
    chk("res_valid", 32'(res_valid), 32'(fifoQ.size() > 0));
    chk("idle", 32'(idle), 32'(inflight.size() == 0 && fifoQ.size() == 0));
    if (fifoQ.size() > 0) begin
      chk("res_id", 32'(res_id), fifoQ[0].id);
      chk("res_c", $signed(res_c), fifoQ[0].c);
    end
    pop = (fifoQ.size() > 0) && res_ready;
    if (g >= 0) begin
      e.id  = g;
      e.c   = ref_mod(laneA[g], laneB[g]);
      e.acc = edgeNum + 1;
    end
    @(posedge clk);
    edgeNum++;
    if (pop) void'(fifoQ.pop_front());
    while (inflight.size() > 0 && inflight[0].acc <= edgeNum - 4)
      fifoQ.push_back(inflight.pop_front());
    if (g >= 0) begin
      inflight.push_back(e);
      rr = (g + 1) % NREQ;
    end
    @(negedge clk);
  endtask

  task automatic randomize_lanes();
    for (int i = 0; i < NREQ; i++) begin
      laneA[i] = rnd_op();
      laneB[i] = rnd_op();
    end
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    res_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  int accBase;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin laneA[i] = 0; laneB[i] = 0; end

    // Reset values
    @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_res_c", $signed(res_c), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // 1) Lane 1 alone, 2*3
    laneA[1] = 2; laneB[1] = 3;
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    for (int i = 0; i < 5; i++) step();
    res_ready = 1'b1;
    step();
    step();

    // 2) Range corner products on lane 0
    req_valid = 4'b0001;
    laneA[0] = 3840;  laneB[0] = 3840; step();
    laneA[0] = -1;    laneB[0] = 5;    step();
    laneA[0] = -3840; laneB[0] = 2;    step();
    drain(8);

    // 3) All lanes requesting, consumer always ready
    req_valid = '1;
    res_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin randomize_lanes(); step(); end
    drain(8);

    // 4) Consumer stalled: credits cap the accepts, one pop frees one slot
    req_valid = '1;
    res_ready = 1'b0;
    accBase = obsAccepts;
    for (int i = 0; i < 12; i++) begin randomize_lanes(); step(); end
    chk("stall_accepts", obsAccepts - accBase, 32'd8);
    accBase = obsAccepts;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("pulse_accepts", obsAccepts - accBase, 32'd1);
    drain(14);

    // 5) Reset in the middle of operation
    req_valid = 4'b0100;
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin randomize_lanes(); step(); end
    req_valid = '0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_idle", 32'(idle), 32'd1);
    inflight.delete();
    fifoQ.delete();
    rr = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // 6) FIFO at 7 entries, then push and pop on the same edge
    res_ready = 1'b0;
    req_valid = 4'b0100;
    for (int i = 0; i < 7; i++) begin randomize_lanes(); step(); end
    req_valid = '0;
    for (int i = 0; i < 5; i++) step();
    randomize_lanes();
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    for (int i = 0; i < 3; i++) step();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    step();
    step();
    drain(12);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      randomize_lanes();
      req_valid = 4'($urandom_range(15));
      res_ready = 1'($urandom_range(1));
      step();
    end
    drain(14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
